popcount_window_stats: RTL and testbench
========================================

// Module: popcount_window_stats
// PURPOSE
//  Downstream consumer of the registered 32-bit popcount stage. Takes one 6-bit
//  ones-count per valid cycle and accumulates fixed-length windows of WIN_LEN samples.
//  Per window it reports the sum, minimum, maximum and hi/lo density alarms.
//  The result goes out through a single-entry valid/ready output register.
// PARAMETERS
//  WIN_LEN    16   samples per window (>=2)
//  CNT_W      6    width of in_count; legal range of a sample is 0..32
//  HI_THRESH  384  out_hi_alarm when window sum > HI_THRESH
//  LO_THRESH  128  out_lo_alarm when window sum < LO_THRESH
//  SUM_W      derived localparam = $clog2(WIN_LEN*32+1); 10 at the default WIN_LEN
// PORTS
//  clk           in   1      clock, rising edge
//  reset_n       in   1      asynchronous active-low reset
//  clear         in   1      synchronous clear of all window and output state
//  in_valid      in   1      in_count is valid this cycle; no backpressure to upstream
//  in_count      in   CNT_W  ones count of one 32-bit word
//  in_range_err  out  1      1-cycle pulse: in_valid with in_count>32
//  out_valid     out  1      window result held in the output register
//  out_ready     in   1      consumer accepts the result when out_valid&&out_ready
//  out_sum       out  SUM_W  sum of the WIN_LEN samples in the window
//  out_min       out  CNT_W  smallest sample in the window
//  out_max       out  CNT_W  largest sample in the window
//  out_hi_alarm  out  1      out_sum > HI_THRESH
//  out_lo_alarm  out  1      out_sum < LO_THRESH
//  overrun_cnt   out  8      saturating count of dropped windows
// BEHAVIOUR
//  Reset values: all outputs 0; window index 0; accumulator 0.
//  Reset is asynchronous (reset_n low), including mid-window; a partial window is discarded.
//  Accept: a sample is accepted when in_valid=1 and in_count<=32.
//   - idx 0: acc=sample, min=max=sample.
//   - otherwise: acc+=sample; min/max updated (ties keep the value).
//   - the sum is computed at SUM_W bits, so it never wraps.
//  Reject: in_valid=1 with in_count>32 pulses in_range_err the next cycle.
//   - the rejected sample does not advance idx and does not touch acc/min/max.
//  Window end: on the accepted sample with idx==WIN_LEN-1:
//   - idx wraps to 0.
//   - the final sum/min/max include that sample.
//   - the result is a candidate for the output register.
//  Output register FSM, 2 states:
//   - EMPTY: candidate loads; out_valid=1 the next cycle; -> FULL.
//   - FULL: out_valid=1 and all out_* are held stable until the handshake.
//   - FULL, handshake and no candidate: -> EMPTY.
//   - FULL, handshake and candidate in the same cycle: the new result loads, stays FULL,
//     no drop.
//   - FULL, no handshake and a candidate: the candidate is discarded, the old result is
//     kept, overrun_cnt++ (saturates at 255).
//  Latency: last sample accepted at cycle N -> out_valid and result visible at N+1.
//  Alarms are computed from the candidate sum and registered with it.
//  clear: highest priority below reset.
//   - zeroes idx, acc, out_valid, overrun_cnt and in_range_err.
//   - a sample presented in the same cycle is ignored.
//  Sample back-to-back: a new window may start on the cycle right after a window end.
// STRUCTURE
//  popcount_pkg (shared):
//   - localparams MAX_COUNT=32, CNT_W=6.
//   - typedef cnt_t (logic [CNT_W-1:0]).
//   - typedef out_state_e {EMPTY,FULL}.
//  Sub-module popcount_win_acc:
//   - holds idx, acc, min, max and range check.
//   - emits a candidate strobe plus sum/min/max.
//  The top holds the output register FSM, alarm compare and overrun counter.
// TESTING
//  1 16 samples of 16, out_ready=1 -> out_valid 1 cycle after the 16th;
//    sum=256, min=max=16, no alarms.
//  2 samples 0..15 -> sum=120, min=0, max=15, lo_alarm=1.
//    Then 16 x 32 -> sum=512, hi_alarm=1.
//  3 out_ready=0 across two full windows -> first result held unchanged, overrun_cnt=1.
//    Then out_ready=1 -> accepted, out_valid=0.
//  4 Window end on the same cycle as a handshake of the previous result
//    -> new result visible next cycle, overrun_cnt unchanged.
//  5 in_count=33 mid-window -> in_range_err pulse; the window still needs 16 legal
//    samples; the sum excludes 33.
//  6 reset_n low after 7 samples, then 16 x 1 -> out_sum=16 (partial discarded).
//    Repeat the same sequence with clear instead of reset.

Source files
------------

// File: rtl/popcount_pkg.sv
// Shared types and constants for the popcount window statistics block.
package popcount_pkg;
    localparam int MAX_COUNT = 32;
    localparam int CNT_W     = 6;

    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } out_state_e;
endpackage

// File: rtl/popcount_win_acc.sv
// Window accumulator: range check, sample index, running sum/min/max and
// a combinational end-of-window candidate that already includes the closing sample.
module popcount_win_acc
    import popcount_pkg::*;
#(
    parameter int WIN_LEN = 16,
    parameter int SUM_W   = 10
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [CNT_W-1:0] in_count,
    output logic             in_range_err,
    output logic             cand_valid,
    output logic [SUM_W-1:0] cand_sum,
    output logic [CNT_W-1:0] cand_min,
    output logic [CNT_W-1:0] cand_max
);
    localparam int IDX_W = $clog2(WIN_LEN);

    logic [IDX_W-1:0] idx;
    logic [SUM_W-1:0] acc;
    cnt_t             min_q;
    cnt_t             max_q;
    logic             legal;
    logic             accept;
    logic             first;
    logic             last;

    assign legal  = (in_count <= cnt_t'(MAX_COUNT));
    assign accept = in_valid && legal && !clear;
    assign first  = (idx == '0);
    assign last   = (idx == IDX_W'(WIN_LEN - 1));

    // Candidate values fold in the current sample so the result can register at the window end.
    assign cand_sum   = first ? SUM_W'(in_count) : acc + SUM_W'(in_count);
    assign cand_min   = (first || (in_count < min_q)) ? in_count : min_q;
    assign cand_max   = (first || (in_count > max_q)) ? in_count : max_q;
    assign cand_valid = accept && last;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx          <= '0;
            acc          <= '0;
            min_q        <= '0;
            max_q        <= '0;
            in_range_err <= 1'b0;
        end else if (clear) begin
            idx          <= '0;
            acc          <= '0;
            min_q        <= '0;
            max_q        <= '0;
            in_range_err <= 1'b0;
        end else begin
            in_range_err <= in_valid && !legal;
            if (accept) begin
                idx   <= last ? '0 : idx + 1'b1;
                acc   <= cand_sum;
                min_q <= cand_min;
                max_q <= cand_max;
            end
        end
    end
endmodule

// File: rtl/popcount_window_stats.sv
// Per-window popcount statistics with a single-entry valid/ready output register,
// density alarms and a saturating count of windows dropped while the register was full.
module popcount_window_stats
    import popcount_pkg::*;
#(
    parameter int  WIN_LEN   = 16,
    parameter int  HI_THRESH = 384,
    parameter int  LO_THRESH = 128,
    localparam int SUM_W     = $clog2(WIN_LEN * MAX_COUNT + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [CNT_W-1:0] in_count,
    output logic             in_range_err,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SUM_W-1:0] out_sum,
    output logic [CNT_W-1:0] out_min,
    output logic [CNT_W-1:0] out_max,
    output logic             out_hi_alarm,
    output logic             out_lo_alarm,
    output logic [7:0]       overrun_cnt,
    output logic             state_dbg
);
    // Handshake: a result transfers on any cycle where out_valid && out_ready;
    // out_* never change while out_valid is high and out_ready is low.
    out_state_e       state;
    out_state_e       next_state;
    logic             cand_valid;
    logic [SUM_W-1:0] cand_sum;
    cnt_t             cand_min;
    cnt_t             cand_max;
    logic             load;
    logic             drop;

    popcount_win_acc #(
        .WIN_LEN (WIN_LEN),
        .SUM_W   (SUM_W)
    ) u_win_acc (
        .clk          (clk),
        .reset_n      (reset_n),
        .clear        (clear),
        .in_valid     (in_valid),
        .in_count     (in_count),
        .in_range_err (in_range_err),
        .cand_valid   (cand_valid),
        .cand_sum     (cand_sum),
        .cand_min     (cand_min),
        .cand_max     (cand_max)
    );

    always_comb begin
        next_state = state;
        load       = 1'b0;
        drop       = 1'b0;
        case (state)
            EMPTY: begin
                if (cand_valid) begin
                    load       = 1'b1;
                    next_state = FULL;
                end
            end
            FULL: begin
                if (out_ready) begin
                    if (cand_valid) load = 1'b1;
                    else            next_state = EMPTY;
                end else if (cand_valid) begin
                    drop = 1'b1;
                end
            end
            default: next_state = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= EMPTY;
            out_sum      <= '0;
            out_min      <= '0;
            out_max      <= '0;
            out_hi_alarm <= 1'b0;
            out_lo_alarm <= 1'b0;
            overrun_cnt  <= '0;
        end else if (clear) begin
            state        <= EMPTY;
            out_sum      <= '0;
            out_min      <= '0;
            out_max      <= '0;
            out_hi_alarm <= 1'b0;
            out_lo_alarm <= 1'b0;
            overrun_cnt  <= '0;
        end else begin
            state <= next_state;
            if (load) begin
                out_sum      <= cand_sum;
                out_min      <= cand_min;
                out_max      <= cand_max;
                out_hi_alarm <= (cand_sum > SUM_W'(HI_THRESH));
                out_lo_alarm <= (cand_sum < SUM_W'(LO_THRESH));
            end
            if (drop && (overrun_cnt != 8'hFF)) overrun_cnt <= overrun_cnt + 8'd1;
        end
    end

    assign out_valid = (state == FULL);
    assign state_dbg = state;
endmodule

// File: tb/tb_popcount_window_stats.sv
// Directed and randomized checks of popcount_window_stats against a queue-based window model.
module tb_popcount_window_stats;
    localparam int WIN_LEN = 16;
    localparam int HI      = 384;
    localparam int LO      = 128;
    localparam int SUM_W   = 10;
    localparam int CNT_W   = 6;
    localparam int W       = SUM_W + 2 * CNT_W;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             clear = 1'b0;
    logic             in_valid = 1'b0;
    logic [CNT_W-1:0] in_count = '0;
    logic             out_ready = 1'b0;
    logic             in_range_err;
    logic             out_valid;
    logic [SUM_W-1:0] out_sum;
    logic [CNT_W-1:0] out_min;
    logic [CNT_W-1:0] out_max;
    logic             out_hi_alarm;
    logic             out_lo_alarm;
    logic [7:0]       overrun_cnt;
    logic             state_dbg;

    popcount_window_stats #(
        .WIN_LEN   (WIN_LEN),
        .HI_THRESH (HI),
        .LO_THRESH (LO)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .clear        (clear),
        .in_valid     (in_valid),
        .in_count     (in_count),
        .in_range_err (in_range_err),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_sum      (out_sum),
        .out_min      (out_min),
        .out_max      (out_max),
        .out_hi_alarm (out_hi_alarm),
        .out_lo_alarm (out_lo_alarm),
        .overrun_cnt  (overrun_cnt),
        .state_dbg    (state_dbg)
    );

    always #5 clk = ~clk;

    // Reference: samples of the open window, results awaiting delivery (at most one).
    int           win_q[$];
    logic [W-1:0] exp_q[$];
    logic         exp_err = 1'b0;
    int           exp_ovr = 0;
    int           n_cmp = 0;
    int           n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic check_all();
        logic [SUM_W-1:0] es;
        logic [CNT_W-1:0] emn;
        logic [CNT_W-1:0] emx;
        chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
        chk("state_dbg", 32'(state_dbg), 32'(exp_q.size() != 0));
        chk("in_range_err", 32'(in_range_err), 32'(exp_err));
        chk("overrun_cnt", 32'(overrun_cnt), exp_ovr);
        if (exp_q.size() != 0) begin
            {es, emn, emx} = exp_q[0];
            chk("out_sum", 32'(out_sum), 32'(es));
            chk("out_min", 32'(out_min), 32'(emn));
            chk("out_max", 32'(out_max), 32'(emx));
            chk("out_hi_alarm", 32'(out_hi_alarm), 32'(int'(es) > HI));
            chk("out_lo_alarm", 32'(out_lo_alarm), 32'(int'(es) < LO));
        end
    endtask

    // One clock: drive inputs, advance the model, then check just after the edge.
    task automatic cycle(input bit v, input int c, input bit rdy, input bit clr);
        bit           hs;
        bit           cand;
        int           s;
        int           mn;
        int           mx;
        logic [W-1:0] res;
        in_valid  = v;
        in_count  = CNT_W'(c);
        out_ready = rdy;
        clear     = clr;
        hs   = (exp_q.size() != 0) && rdy;
        cand = 0;
        res  = '0;
        if (clr) begin
            win_q.delete();
            exp_q.delete();
            exp_ovr = 0;
            exp_err = 1'b0;
        end else begin
            exp_err = v && (c > 32);
            if (v && c <= 32) begin
                win_q.push_back(c);
                if (win_q.size() == WIN_LEN) begin
                    s = 0; mn = 1000; mx = -1;
                    foreach (win_q[i]) begin
                        s += win_q[i];
                        if (win_q[i] < mn) mn = win_q[i];
                        if (win_q[i] > mx) mx = win_q[i];
                    end
                    res  = {SUM_W'(s), CNT_W'(mn), CNT_W'(mx)};
                    cand = 1;
                    win_q.delete();
                end
            end
            if (hs) void'(exp_q.pop_front());
            if (cand) begin
                if (exp_q.size() == 0) exp_q.push_back(res);
                else if (exp_ovr < 255) exp_ovr++;
            end
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        in_valid = 1'b0;
        clear = 1'b0;
        win_q.delete();
        exp_q.delete();
        exp_ovr = 0;
        exp_err = 1'b0;
        #2;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_range_err", 32'(in_range_err), 0);
        chk("rst_sum", 32'(out_sum), 0);
        chk("rst_min_max", 32'({out_min, out_max}), 0);
        chk("rst_alarms", 32'({out_hi_alarm, out_lo_alarm}), 0);
        chk("rst_overrun", 32'(overrun_cnt), 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic window(input int val, input bit rdy);
        for (int i = 0; i < WIN_LEN; i++) cycle(1, val, rdy, 0);
    endtask

    initial begin
        int c;
        #3;
        do_reset();

        // 1: constant 16s
        window(16, 1);
        chk("t1_sum", 32'(out_sum), 256);
        chk("t1_minmax", 32'({out_min, out_max}), {6'd16, 6'd16});
        chk("t1_alarms", 32'({out_hi_alarm, out_lo_alarm}), 0);
        cycle(0, 0, 1, 0);

        // 2: ramp then saturated window
        for (int i = 0; i < WIN_LEN; i++) cycle(1, i, 1, 0);
        chk("t2_sum", 32'(out_sum), 120);
        chk("t2_lo", 32'(out_lo_alarm), 1);
        window(32, 1);
        chk("t2_sum512", 32'(out_sum), 512);
        chk("t2_hi", 32'(out_hi_alarm), 1);
        cycle(0, 0, 1, 0);

        // 3: stalled consumer across two windows
        window(5, 0);
        window(6, 0);
        chk("t3_held_sum", 32'(out_sum), 80);
        chk("t3_overrun", 32'(overrun_cnt), 1);
        cycle(0, 0, 1, 0);
        chk("t3_drained", 32'(out_valid), 0);

        // 4: window end coincides with handshake
        window(2, 0);
        for (int i = 0; i < WIN_LEN - 1; i++) cycle(1, 3, 0, 0);
        cycle(1, 3, 1, 0);
        chk("t4_sum", 32'(out_sum), 48);
        chk("t4_overrun", 32'(overrun_cnt), 1);
        cycle(0, 0, 1, 0);

        // 5: out-of-range sample mid-window
        for (int i = 0; i < 8; i++) cycle(1, 4, 1, 0);
        cycle(1, 33, 1, 0);
        cycle(0, 0, 1, 0);
        chk("t5_err_pulse_gone", 32'(in_range_err), 0);
        for (int i = 0; i < 8; i++) cycle(1, 4, 1, 0);
        chk("t5_sum", 32'(out_sum), 64);
        cycle(0, 0, 1, 0);

        // 6: partial window discarded by reset, then by clear
        for (int i = 0; i < 7; i++) cycle(1, 9, 1, 0);
        do_reset();
        window(1, 1);
        chk("t6_reset_sum", 32'(out_sum), 16);
        cycle(0, 0, 1, 0);
        for (int i = 0; i < 7; i++) cycle(1, 9, 1, 0);
        cycle(1, 9, 1, 1);
        chk("t6_clear_overrun", 32'(overrun_cnt), 0);
        window(1, 1);
        chk("t6_clear_sum", 32'(out_sum), 16);
        cycle(0, 0, 1, 0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            c = ($urandom_range(0, 9) == 0) ? $urandom_range(33, 63) : $urandom_range(0, 32);
            cycle($urandom_range(0, 3) != 0, c, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 299) == 0);
        end

        // Overrun saturation
        cycle(0, 0, 1, 1);
        for (int w = 0; w < 258; w++) window($urandom_range(0, 32), 0);
        chk("sat_overrun", 32'(overrun_cnt), 255);
        cycle(0, 0, 1, 0);
        cycle(0, 0, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
